// File: rtl/branch_detector_multi.sv
// rtl/branch_detector_multi.sv - per-thread multi-entry branch detector with replay on annulled instructions
// Five register ranks from the stage-0 capture to the outputs; the thread id rides along to index the replay table.

module branch_detector_multi #(
  parameter int WORD_WIDTH         = 36,
  parameter int PC_WIDTH           = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int BRANCH_COUNT       = 4,
  parameter int BRANCH_INDEX_WIDTH = 2,
  parameter int FLAG_COUNT         = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [PC_WIDTH-1:0]           pc,
  input  logic [FLAG_COUNT-1:0]         flags_previous,
  input  logic                          IO_ready_previous,
  input  logic                          config_wren,
  input  logic [BRANCH_INDEX_WIDTH-1:0] config_entry,
  input  logic [WORD_WIDTH-1:0]         config_data,
  output logic [PC_WIDTH-1:0]           destination,
  output logic [BRANCH_INDEX_WIDTH-1:0] branch_index,
  output logic                          jump,
  output logic                          cancel
);

  localparam int CONFIG_WIDTH = 2*PC_WIDTH + 2*FLAG_COUNT + 5;
  localparam int VAL_LSB      = 5;
  localparam int MASK_LSB     = VAL_LSB + FLAG_COUNT;
  localparam int DEST_LSB     = MASK_LSB + FLAG_COUNT;
  localparam int ORIG_LSB     = DEST_LSB + PC_WIDTH;
  localparam int B_PE = 0, B_PT = 1, B_OE = 2, B_VALID = 3, B_INV = 4;

  logic [THREAD_COUNT_WIDTH-1:0] thr;
  logic [CONFIG_WIDTH-1:0]       cfg_mem [THREAD_COUNT][BRANCH_COUNT];
  logic [CONFIG_WIDTH-1:0]       cfg_wdata;

  // A WORD_WIDTH narrower than CONFIG_WIDTH zero-fills the high (origin) field.
  assign cfg_wdata = CONFIG_WIDTH'(config_data);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thr <= '0;
      for (int t = 0; t < THREAD_COUNT; t++)
        for (int e = 0; e < BRANCH_COUNT; e++)
          cfg_mem[t][e] <= '0;
    end else begin
      thr <= (thr == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ? '0 : thr + 1'b1;
      if (config_wren && (int'(config_entry) < BRANCH_COUNT))
        cfg_mem[thr][config_entry] <= cfg_wdata;
    end
  end

  // Stage 0 capture and stage 1 hold; the config read shares the write edge, so it sees old data.
  logic [PC_WIDTH-1:0]           pc_s0, pc_s1;
  logic [FLAG_COUNT-1:0]         flags_s0, flags_s1;
  logic [THREAD_COUNT_WIDTH-1:0] thr_s0, thr_s1, thr_s2, thr_s3;
  logic [CONFIG_WIDTH-1:0]       cfg_s0 [BRANCH_COUNT];
  logic [CONFIG_WIDTH-1:0]       cfg_s1 [BRANCH_COUNT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_s0 <= '0; pc_s1 <= '0;
      flags_s0 <= '0; flags_s1 <= '0;
      thr_s0 <= '0; thr_s1 <= '0;
      for (int e = 0; e < BRANCH_COUNT; e++) begin
        cfg_s0[e] <= '0;
        cfg_s1[e] <= '0;
      end
    end else begin
      pc_s0 <= pc; pc_s1 <= pc_s0;
      flags_s0 <= flags_previous; flags_s1 <= flags_s0;
      thr_s0 <= thr; thr_s1 <= thr_s0;
      for (int e = 0; e < BRANCH_COUNT; e++) begin
        cfg_s0[e] <= cfg_mem[thr][e];
        cfg_s1[e] <= cfg_s0[e];
      end
    end
  end

  logic [BRANCH_COUNT-1:0] match_c, pred_c, match_s2, pred_s2, pe_s2, pt_s2;
  logic [PC_WIDTH-1:0]     dest_s2 [BRANCH_COUNT];

  always_comb begin
    match_c = '0;
    pred_c  = '0;
    for (int e = 0; e < BRANCH_COUNT; e++) begin
      match_c[e] = cfg_s1[e][B_VALID] &
                   (!cfg_s1[e][B_OE] || (pc_s1 == cfg_s1[e][ORIG_LSB +: PC_WIDTH]));
      pred_c[e]  = (((flags_s1 ^ cfg_s1[e][VAL_LSB +: FLAG_COUNT]) &
                     cfg_s1[e][MASK_LSB +: FLAG_COUNT]) == '0) ^ cfg_s1[e][B_INV];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_s2 <= '0; pred_s2 <= '0; pe_s2 <= '0; pt_s2 <= '0; thr_s2 <= '0;
      for (int e = 0; e < BRANCH_COUNT; e++) dest_s2[e] <= '0;
    end else begin
      match_s2 <= match_c;
      pred_s2  <= pred_c;
      thr_s2   <= thr_s1;
      for (int e = 0; e < BRANCH_COUNT; e++) begin
        pe_s2[e]   <= cfg_s1[e][B_PE];
        pt_s2[e]   <= cfg_s1[e][B_PT];
        dest_s2[e] <= cfg_s1[e][DEST_LSB +: PC_WIDTH];
      end
    end
  end

  logic                          win_jump, win_cancel, miss_cancel, cancel_c;
  logic [PC_WIDTH-1:0]           win_dest;
  logic [BRANCH_INDEX_WIDTH-1:0] win_idx;

  // Scan high to low so the lowest matching entry is the last one assigned.
  always_comb begin
    win_jump    = 1'b0;
    win_cancel  = 1'b0;
    win_dest    = '0;
    win_idx     = '0;
    miss_cancel = 1'b0;
    for (int e = BRANCH_COUNT - 1; e >= 0; e--) begin
      miss_cancel = miss_cancel | (match_s2[e] & pe_s2[e] & pt_s2[e]);
      if (match_s2[e] && pred_s2[e]) begin
        win_jump   = 1'b1;
        win_dest   = dest_s2[e];
        win_idx    = BRANCH_INDEX_WIDTH'(e);
        win_cancel = pe_s2[e] & !pt_s2[e];
      end
    end
    cancel_c = win_jump ? win_cancel : miss_cancel;
  end

  logic                          jump_s3, cancel_s3;
  logic [PC_WIDTH-1:0]           dest_s3;
  logic [BRANCH_INDEX_WIDTH-1:0] idx_s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jump_s3 <= 1'b0; cancel_s3 <= 1'b0; dest_s3 <= '0; idx_s3 <= '0; thr_s3 <= '0;
    end else begin
      jump_s3   <= win_jump;
      cancel_s3 <= cancel_c;
      dest_s3   <= win_dest;
      idx_s3    <= win_idx;
      thr_s3    <= thr_s2;
    end
  end

  logic                          saved_jump [THREAD_COUNT];
  logic [PC_WIDTH-1:0]           saved_dest [THREAD_COUNT];
  logic [BRANCH_INDEX_WIDTH-1:0] saved_idx  [THREAD_COUNT];

  // An annulled previous instruction replays the thread's last accepted decision without cancelling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jump <= 1'b0; cancel <= 1'b0; destination <= '0; branch_index <= '0;
      for (int t = 0; t < THREAD_COUNT; t++) begin
        saved_jump[t] <= 1'b0;
        saved_dest[t] <= '0;
        saved_idx[t]  <= '0;
      end
    end else if (IO_ready_previous) begin
      jump               <= jump_s3;
      cancel             <= cancel_s3;
      destination        <= dest_s3;
      branch_index       <= idx_s3;
      saved_jump[thr_s3] <= jump_s3;
      saved_dest[thr_s3] <= dest_s3;
      saved_idx[thr_s3]  <= idx_s3;
    end else begin
      jump         <= saved_jump[thr_s3];
      cancel       <= 1'b0;
      destination  <= saved_dest[thr_s3];
      branch_index <= saved_idx[thr_s3];
    end
  end

endmodule
